// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 32x32 register file with bypassed reads and a pending-write scoreboard.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              stall,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic [NREGS-1:0]  pend_next;
  logic              wr_hit1;
  logic              wr_hit2;
  logic              hit1;
  logic              hit2;

  // A new producer (pend_set) wins over a completing write to the same register.
  always_comb begin
    pend_next = pend;
    if (we) pend_next[wa] = 1'b0;
    if (pend_set && pend_addr != '0) pend_next[pend_addr] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pend <= '0;
    end else begin
      if (we && wa != '0) regs[wa] <= wd;
      pend <= pend_next;
    end
  end

  assign wr_hit1 = we && (wa == ra1) && (ra1 != '0);
  assign wr_hit2 = we && (wa == ra2) && (ra2 != '0);
  assign hit1    = pend[ra1] && !wr_hit1;
  assign hit2    = pend[ra2] && !wr_hit2;

  // Outputs are gated by rst_n so that a held reset hides the same-cycle bypass too.
  always_comb begin
    rd1      = '0;
    rd2      = '0;
    dbg_data = '0;
    stall    = 1'b0;
    if (rst_n) begin
      if (wr_hit1)          rd1 = wd;
      else if (ra1 != '0)   rd1 = regs[ra1];
      if (wr_hit2)          rd2 = wd;
      else if (ra2 != '0)   rd2 = regs[ra2];
      if (dbg_addr != '0)   dbg_data = regs[dbg_addr];
      stall = hit1 || hit2;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - randomized and directed checks of regfile_scoreboard against a reference model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, pend_addr = '0, dbg_addr = '0;
  logic [31:0] rd1, rd2, wd = '0, dbg_data;
  logic        we = 1'b0, pend_set = 1'b0, stall;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_reg [32];
  bit          m_pend [32];

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .pend_set(pend_set), .pend_addr(pend_addr),
    .stall(stall), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] ra);
    if (!rst_n || ra == 0) return '0;
    if (we && wa == ra)    return wd;
    return m_reg[ra];
  endfunction

  function automatic bit exp_stall();
    bit s1, s2;
    if (!rst_n) return 1'b0;
    s1 = (ra1 != 0) && m_pend[ra1] && !(we && wa == ra1);
    s2 = (ra2 != 0) && m_pend[ra2] && !(we && wa == ra2);
    return s1 || s2;
  endfunction

  task automatic check_all(input string tag);
    #1;
    check({tag, ".rd1"}, rd1, exp_read(ra1));
    check({tag, ".rd2"}, rd2, exp_read(ra2));
    check({tag, ".stall"}, {31'b0, stall}, {31'b0, exp_stall()});
    check({tag, ".dbg"}, dbg_data, (!rst_n || dbg_addr == 0) ? 32'h0 : m_reg[dbg_addr]);
  endtask

  // Advance one clock: the model applies the architectural update the DUT sees at the edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_clear();
    else begin
      if (we && wa != 0) m_reg[wa] = wd;
      if (we) m_pend[wa] = 1'b0;
      if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; pend_set = 0; wa = 0; wd = 0; pend_addr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    @(negedge clk);
    // 1: reset then read, with a held-reset write attempt that must stay hidden
    we = 1; wa = 5; wd = 32'h12345678; ra1 = 5; ra2 = 31;
    check_all("rst_held");
    cycle();
    idle();
    cycle();
    rst_n = 1;
    check_all("rst_rel");
    check("rst.rd1", rd1, 32'h0);
    check("rst.stall", {31'b0, stall}, 32'h0);

    // 2: write/read and $zero
    we = 1; wa = 5'b01010; wd = 32'hDEADBEEF; cycle();
    idle(); ra1 = 10; check_all("wr10");
    check("wr10.rd1", rd1, 32'hDEADBEEF);
    we = 1; wa = 0; wd = 32'hFFFFFFFF; cycle();
    idle(); ra1 = 0; dbg_addr = 0; check_all("wr0");
    check("wr0.rd1", rd1, 32'h0);
    check("wr0.dbg", dbg_data, 32'h0);

    // 3: bypass vs debug port
    we = 1; wa = 3; wd = 32'h1111; cycle();
    we = 1; wa = 3; wd = 32'h2222; ra2 = 3; dbg_addr = 3; check_all("byp");
    check("byp.rd2", rd2, 32'h2222);
    check("byp.dbg", dbg_data, 32'h1111);
    cycle();
    idle(); check_all("byp_after");
    check("byp_after.dbg", dbg_data, 32'h2222);

    // 4: scoreboard stall and clear
    ra2 = 0; pend_set = 1; pend_addr = 28; cycle();
    idle(); ra1 = 28; check_all("pend28");
    check("pend28.stall", {31'b0, stall}, 32'h1);
    we = 1; wa = 28; wd = 32'h00ABCDEF; check_all("pend28_wr");
    check("pend28_wr.stall", {31'b0, stall}, 32'h0);
    check("pend28_wr.rd1", rd1, 32'h00ABCDEF);
    cycle();
    idle(); check_all("pend28_clr");
    check("pend28_clr.stall", {31'b0, stall}, 32'h0);

    // 5: simultaneous set and clear
    pend_set = 1; pend_addr = 7; cycle();
    we = 1; wa = 7; wd = 32'h77777777; pend_set = 1; pend_addr = 7; cycle();
    idle(); ra1 = 0; ra2 = 7; dbg_addr = 7; check_all("setclr");
    check("setclr.stall", {31'b0, stall}, 32'h1);
    check("setclr.dbg", dbg_data, 32'h77777777);

    // 6: asynchronous reset mid-operation
    pend_set = 1; pend_addr = 3; cycle();
    pend_set = 1; pend_addr = 28; we = 1; wa = 10; wd = 32'hCAFEF00D; cycle();
    idle(); ra1 = 10; ra2 = 3; dbg_addr = 10; check_all("pre_arst");
    #1 rst_n = 0; model_clear();
    #1;
    check("arst.rd1", rd1, 32'h0);
    check("arst.stall", {31'b0, stall}, 32'h0);
    check("arst.dbg", dbg_data, 32'h0);
    #1 rst_n = 1;
    ra2 = 28; check_all("post_arst");

    // randomized traffic with biased small addresses to provoke hits
    for (int n = 0; n < 600; n++) begin
      we        = ($urandom_range(0, 99) < 50);
      pend_set  = ($urandom_range(0, 99) < 35);
      wa        = 5'($urandom_range(0, 99) < 70 ? $urandom_range(0, 7) : $urandom_range(0, 31));
      pend_addr = 5'($urandom_range(0, 99) < 70 ? $urandom_range(0, 7) : $urandom_range(0, 31));
      ra1       = 5'($urandom_range(0, 99) < 70 ? $urandom_range(0, 7) : $urandom_range(0, 31));
      ra2       = 5'($urandom_range(0, 99) < 70 ? $urandom_range(0, 7) : $urandom_range(0, 31));
      dbg_addr  = 5'($urandom_range(0, 31));
      wd        = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 0;
        model_clear();
      end else begin
        rst_n = 1;
      end
      check_all("rand");
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
